// File: rtl/spad_fifo_ctrl.sv
// Ring-buffer FIFO controller around a dual-port scratchpad with 1-cycle read latency.
// A 2-entry output buffer hides the spad read latency so the stream runs at one word per cycle.
module spad_fifo_ctrl #(
    parameter int DATA_WIDTH = 8,
    parameter int ADDR_WIDTH = 4
) (
    input  logic                  clk_i,
    input  logic                  rst_ni,
    input  logic                  flush_i,
    input  logic                  wr_valid_i,
    output logic                  wr_ready_o,
    input  logic [DATA_WIDTH-1:0] wr_data_i,
    output logic                  rd_valid_o,
    input  logic                  rd_ready_i,
    output logic [DATA_WIDTH-1:0] rd_data_o,
    output logic [ADDR_WIDTH+1:0] count_o,
    output logic                  full_o,
    output logic                  empty_o,
    output logic                  spad_we_o,
    output logic [ADDR_WIDTH-1:0] spad_addr_w_o,
    output logic [DATA_WIDTH-1:0] spad_data_o,
    output logic                  spad_re_o,
    output logic [ADDR_WIDTH-1:0] spad_addr_r_o,
    input  logic [DATA_WIDTH-1:0] spad_data_i
);

    localparam int DEPTH = 1 << ADDR_WIDTH;
    localparam int CW    = ADDR_WIDTH + 1;
    localparam int NW    = ADDR_WIDTH + 2;

    logic [ADDR_WIDTH-1:0] wr_ptr_q, wr_ptr_d;
    logic [ADDR_WIDTH-1:0] rd_ptr_q, rd_ptr_d;
    logic [CW-1:0]         spad_cnt_q, spad_cnt_d;
    logic                  inflight_q, inflight_d;
    logic [DATA_WIDTH-1:0] obuf_q [2];
    logic [DATA_WIDTH-1:0] obuf_d [2];
    logic                  ob_head_q, ob_head_d;
    logic [1:0]            ob_cnt_q, ob_cnt_d;

    logic                  wr_ready_s;
    logic                  rd_valid_s;
    logic                  push_s;
    logic                  pop_s;
    logic                  issue_s;
    logic [2:0]            ob_load_s;
    logic [1:0]            ob_after_pop_s;

    // Handshakes and read-issue decision
    always_comb begin
        wr_ready_s = (spad_cnt_q < CW'(DEPTH)) & ~flush_i;
        rd_valid_s = (ob_cnt_q != 2'd0) & ~flush_i;
        push_s     = wr_valid_i & wr_ready_s;
        pop_s      = rd_valid_s & rd_ready_i;
        // Output-buffer slots already claimed once this cycle's pop leaves
        ob_load_s  = {1'b0, ob_cnt_q} + {2'b00, inflight_q} - {2'b00, pop_s};
        issue_s    = (spad_cnt_q != CW'(0)) & (ob_load_s < 3'd2) & ~flush_i;
    end

    // Next-state for pointers, occupancy and output buffer
    always_comb begin
        wr_ptr_d       = wr_ptr_q;
        rd_ptr_d       = rd_ptr_q;
        spad_cnt_d     = spad_cnt_q;
        inflight_d     = inflight_q;
        obuf_d[0]      = obuf_q[0];
        obuf_d[1]      = obuf_q[1];
        ob_head_d      = ob_head_q;
        ob_cnt_d       = ob_cnt_q;
        ob_after_pop_s = ob_cnt_q - {1'b0, pop_s};
        if (flush_i) begin
            wr_ptr_d   = '0;
            rd_ptr_d   = '0;
            spad_cnt_d = '0;
            inflight_d = 1'b0;
            ob_head_d  = 1'b0;
            ob_cnt_d   = 2'd0;
        end else begin
            wr_ptr_d   = wr_ptr_q + ADDR_WIDTH'(push_s);
            rd_ptr_d   = rd_ptr_q + ADDR_WIDTH'(issue_s);
            spad_cnt_d = spad_cnt_q + CW'(push_s) - CW'(issue_s);
            inflight_d = issue_s;
            ob_head_d  = ob_head_q ^ pop_s;
            ob_cnt_d   = ob_after_pop_s + {1'b0, inflight_q};
            if (inflight_q) begin
                obuf_d[ob_head_d ^ ob_after_pop_s[0]] = spad_data_i;
            end else begin
                obuf_d[0] = obuf_q[0];
            end
        end
    end

    // State registers
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            spad_cnt_q <= '0;
            inflight_q <= 1'b0;
            obuf_q[0]  <= '0;
            obuf_q[1]  <= '0;
            ob_head_q  <= 1'b0;
            ob_cnt_q   <= 2'd0;
        end else begin
            wr_ptr_q   <= wr_ptr_d;
            rd_ptr_q   <= rd_ptr_d;
            spad_cnt_q <= spad_cnt_d;
            inflight_q <= inflight_d;
            obuf_q[0]  <= obuf_d[0];
            obuf_q[1]  <= obuf_d[1];
            ob_head_q  <= ob_head_d;
            ob_cnt_q   <= ob_cnt_d;
        end
    end

    assign wr_ready_o    = wr_ready_s;
    assign rd_valid_o    = rd_valid_s;
    assign rd_data_o     = obuf_q[ob_head_q];
    assign spad_we_o     = push_s & rst_ni;
    assign spad_addr_w_o = wr_ptr_q;
    assign spad_data_o   = wr_data_i;
    assign spad_re_o     = issue_s;
    assign spad_addr_r_o = rd_ptr_q;
    assign count_o       = NW'(spad_cnt_q) + NW'(inflight_q) + NW'(ob_cnt_q);
    assign full_o        = (spad_cnt_q == CW'(DEPTH));
    assign empty_o       = (count_o == NW'(0));

endmodule

// File: doc/spad_fifo_ctrl.md
# spad_fifo_ctrl

Ring-buffer FIFO controller that sequences one dual-port scratchpad (separate read/write ports, 1-cycle synchronous read, no reset of contents) into a valid/ready stream buffer. Used in front of PE-local spads to decouple NoC delivery from PE consumption. The controller owns the pointers, occupancy and a 2-entry output buffer that hides the spad read latency. It guarantees the spad rule that read and write addresses differ whenever both enables are high.

## Interface
- DATA_WIDTH, 8, word width; must match the attached spad.
- ADDR_WIDTH, 4, spad address width; spad depth DEPTH = 2^ADDR_WIDTH.
- clk_i  in  1  clock; all state updates on rising edge.
- rst_ni  in  1  reset; one clock, reset is asynchronous and active-low.
- flush_i  in  1  synchronous clear of all queued data.
- wr_valid_i  in  1  producer has a word.
- wr_ready_o  out  1  controller accepts a word this cycle.
- wr_data_i  in  DATA_WIDTH  producer word.
- rd_valid_o  out  1  rd_data_o holds the oldest word.
- rd_ready_i  in  1  consumer takes the word.
- rd_data_o  out  DATA_WIDTH  oldest word (output-buffer head).
- count_o  out  ADDR_WIDTH+2  words held: spad + in-flight + output buffer.
- full_o  out  1  spad occupancy == DEPTH.
- empty_o  out  1  count_o == 0.
- spad_we_o  out  1  spad write enable.
- spad_addr_w_o  out  ADDR_WIDTH  spad write address (= wr_ptr).
- spad_data_o  out  DATA_WIDTH  spad write data (= wr_data_i).
- spad_re_o  out  1  spad read enable.
- spad_addr_r_o  out  ADDR_WIDTH  spad read address (= rd_ptr).
- spad_data_i  in  DATA_WIDTH  spad read data, valid the cycle after spad_re_o.

## Operation
- State: wr_ptr, rd_ptr (ADDR_WIDTH, wrap DEPTH-1 -> 0), spad_cnt (0..DEPTH), inflight flag, output buffer obuf[2] with ob_cnt (0..2).
- push = wr_valid_i & wr_ready_o; wr_ready_o = (spad_cnt < DEPTH) & ~flush_i. spad_we_o = push & rst_ni; wr_ptr++ on push.
- pop = rd_valid_o & rd_ready_i; rd_valid_o = (ob_cnt != 0) & ~flush_i; rd_data_o = obuf head.
- Read issue: spad_re_o = (spad_cnt != 0) & (ob_cnt + inflight - pop < 2) & ~flush_i; rd_ptr++ and spad_cnt-- on issue; inflight_next = spad_re_o.
- Return: when inflight, spad_data_i is written into obuf at the tail (after this cycle's pop) in that cycle's edge.
- spad_cnt_next = spad_cnt + push - spad_re_o; push and issue in the same cycle leave it unchanged.
- No write->read bypass: a word pushed into an empty spad is readable from the next cycle only.
- Address safety invariant: spad_we_o & spad_re_o implies spad_addr_w_o != spad_addr_r_o (issue needs spad_cnt>0, push needs spad_cnt<DEPTH). The bench asserts this every cycle.
- count_o = spad_cnt + inflight + ob_cnt; max DEPTH+2. full_o reflects the spad only.
- flush_i: highest priority. Pointers, spad_cnt, ob_cnt and inflight clear at the edge. Data returning from an in-flight read is dropped. No spad access is issued in the flush cycle.
- Spad contents are never cleared; stale data is unreachable after flush or reset.

## Timing
- Reset (async, rst_ni low): all state 0.
- Reset output values: rd_valid_o 0, count_o 0, empty_o 1, full_o 0, spad_re_o 0, spad_we_o 0, wr_ready_o 1.
- The producer must not assert wr_valid_i while rst_ni is low. The controller never writes the spad while rst_ni is low.
- First-word latency, empty FIFO:
  - Push in cycle 0.
  - spad_re_o in cycle 1.
  - Word captured at the end of cycle 2.
  - rd_valid_o in cycle 3.
- Steady state: 1 word/cycle in and out simultaneously, with no bubbles while count_o >= 3.
- Consumer stall: at most 2 words leave the spad beyond the consumer (obuf full). spad_re_o stays low until a pop.
- Reset asserted mid-operation: all state clears immediately; any in-flight return is ignored after release.
- count_o, full_o and empty_o are registered-state derived and update one edge after the causing event.

## Test plan
- Reset then single push of 0xA5 in cycle 0, rd_ready_i=1 -> spad_re_o in cycle 1, rd_valid_o=1 with rd_data_o=0xA5 in cycle 3, count_o back to 0 and empty_o=1 after pop.
- DEPTH=16, rd_ready_i=0, push 0..19 -> 18 accepted (16 spad + 2 obuf), wr_ready_o=0 and full_o=1 once the spad holds 16, count_o=18.
- From full, drain with rd_ready_i=1 -> outputs 0..17 in order, with wr_ptr/rd_ptr wrap exercised.
- Simultaneous continuous push/pop of 100 random words with random rd_ready_i -> output order exact, address-safety assertion never fires, and throughput is 1/cycle when rd_ready_i=1 and count_o>=3.
- Data returning from an in-flight read, with flush_i in the cycle after spad_re_o -> returned word dropped, count_o=0, rd_valid_o stays 0, next pushed word 0x3C is the first word read.
- rst_ni pulsed low mid-stream with 5 words queued -> outputs take their reset values immediately, no stale word is ever presented, and a new push of 0x11 reads back as 0x11.
